// File: rtl/multi_debounce_button.sv
// N-channel button debouncer: per-channel sync + polarity, debounced level,
// one-cycle rise/fall/long-press strobes; shared run-time count/delay config.
// Ports: clk, reset (sync, active-high); *_delay/*_min_count/long_press_count
// config (CNT_W); din_bounce raw pins; dout_debounced, rise_pulse,
// fall_pulse, long_press per-channel outputs (NUM_CH).
module multi_debounce_button #(
  parameter int          NUM_CH          = 4,
  parameter int          CNT_W           = 32,
  parameter int          SYNC_STAGES     = 2,
  parameter logic [31:0] ACTIVE_LOW_MASK = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  post_rising_edge_delay,
  input  logic [CNT_W-1:0]  post_falling_edge_delay,
  input  logic [CNT_W-1:0]  rising_edge_min_count,
  input  logic [CNT_W-1:0]  falling_edge_min_count,
  input  logic [CNT_W-1:0]  long_press_count,
  input  logic [NUM_CH-1:0] din_bounce,
  output logic [NUM_CH-1:0] dout_debounced,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] long_press
);

  typedef enum logic [2:0] {
    INIT, START, LOW, HIGH, HOLD_R, HOLD_F
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] INIT_WAIT = CNT_W'(SYNC_STAGES);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  // Zero thresholds behave as 1 so a channel can never stall.
  logic [CNT_W-1:0] rise_thr, fall_thr;
  logic [CNT_W-1:0] rdly_thr, fdly_thr;

  assign rise_thr = (rising_edge_min_count == '0) ?
                    ONE : rising_edge_min_count;
  assign fall_thr = (falling_edge_min_count == '0) ?
                    ONE : falling_edge_min_count;
  assign rdly_thr = (post_rising_edge_delay == '0) ?
                    ONE : post_rising_edge_delay;
  assign fdly_thr = (post_falling_edge_delay == '0) ?
                    ONE : post_falling_edge_delay;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       min_q, min_d;
    logic [CNT_W-1:0]       dly_q, dly_d;
    logic [CNT_W-1:0]       lp_q, lp_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   lpp_q, lpp_d;
    logic                   s;
    logic                   lp_run;
    logic [CNT_W-1:0]       min_inc, dly_inc;

    assign s       = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK[i];
    assign min_inc = sat_inc(min_q);
    assign dly_inc = sat_inc(dly_q);
    // Counter stops at the threshold, so the strobe fires once per press.
    assign lp_run  = (long_press_count != '0) &&
                     (lp_q < long_press_count);

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q  <= '0;
        state_q <= INIT;
        min_q   <= '0;
        dly_q   <= '0;
        lp_q    <= '0;
        dout_q  <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        lpp_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], din_bounce[i]};
        state_q <= state_d;
        min_q   <= min_d;
        dly_q   <= dly_d;
        lp_q    <= lp_d;
        dout_q  <= dout_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        lpp_q   <= lpp_d;
      end
    end

    always_comb begin
      state_d = state_q;
      min_d   = min_q;
      dly_d   = dly_q;
      lp_d    = lp_q;
      dout_d  = dout_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      lpp_d   = 1'b0;
      unique case (state_q)
        INIT: begin
          // Min counter doubles as the flush timer.
          if (min_q >= INIT_WAIT) begin
            state_d = START;
          end else begin
            min_d = min_inc;
          end
        end
        START: begin
          dout_d  = s;
          min_d   = '0;
          dly_d   = '0;
          lp_d    = '0;
          state_d = s ? HIGH : LOW;
        end
        LOW: begin
          min_d = s ? min_inc : '0;
          if (s && (min_inc >= rise_thr)) begin
            dout_d  = 1'b1;
            rise_d  = 1'b1;
            min_d   = '0;
            dly_d   = '0;
            lp_d    = '0;
            state_d = HOLD_R;
          end
        end
        HIGH: begin
          min_d = !s ? min_inc : '0;
          if (!s && (min_inc >= fall_thr)) begin
            dout_d  = 1'b0;
            fall_d  = 1'b1;
            min_d   = '0;
            dly_d   = '0;
            lp_d    = '0;
            state_d = HOLD_F;
          end else if (lp_run) begin
            lp_d  = lp_q + ONE;
            lpp_d = (lp_q + ONE == long_press_count);
          end
        end
        HOLD_R: begin
          dly_d = dly_inc;
          if (dly_inc >= rdly_thr) begin
            min_d   = '0;
            state_d = HIGH;
          end
          if (lp_run) begin
            lp_d  = lp_q + ONE;
            lpp_d = (lp_q + ONE == long_press_count);
          end
        end
        HOLD_F: begin
          dly_d = dly_inc;
          if (dly_inc >= fdly_thr) begin
            min_d   = '0;
            state_d = LOW;
          end
        end
        default: state_d = INIT;
      endcase
    end

    assign dout_debounced[i] = dout_q;
    assign rise_pulse[i]     = rise_q;
    assign fall_pulse[i]     = fall_q;
    assign long_press[i]     = lpp_q;
  end

endmodule

// File: tb/tb_multi_debounce_button.sv
// Directed bench for multi_debounce_button: startup, bounce, lockout,
// active-low channel, long press, threshold change, reset mid-operation.
module tb_multi_debounce_button;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rdly = 32'd10;
  logic [31:0] fdly = 32'd10;
  logic [31:0] rmin = 32'd5;
  logic [31:0] fmin = 32'd5;
  logic [31:0] lpc  = 32'd0;
  logic [3:0]  din  = 4'b0111;
  logic [3:0]  dout, rp, fp, lp;

  int n_assert = 0;
  int n_fail   = 0;
  int rise_cnt [4];
  int fall_cnt [4];
  int lp_cnt   [4];
  int snap;

  multi_debounce_button #(
    .NUM_CH(4),
    .CNT_W(32),
    .SYNC_STAGES(2),
    .ACTIVE_LOW_MASK(32'h2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .post_rising_edge_delay(rdly),
    .post_falling_edge_delay(fdly),
    .rising_edge_min_count(rmin),
    .falling_edge_min_count(fmin),
    .long_press_count(lpc),
    .din_bounce(din),
    .dout_debounced(dout),
    .rise_pulse(rp),
    .fall_pulse(fp),
    .long_press(lp)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 4; k++) begin
      rise_cnt[k] = 0;
      fall_cnt[k] = 0;
      lp_cnt[k]   = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (rp[k]) rise_cnt[k]++;
        if (fp[k]) fall_cnt[k]++;
        if (lp[k]) lp_cnt[k]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Startup: raw 0111 with ch1 active-low gives levels 0101.
    tick(3);
    chk("rst_dout", dout, 4'b0000);
    chk("rst_pulses", {rp, fp, lp}, 12'h000);
    reset = 1'b0;
    tick(3);
    chk("start_early", dout, 4'b0000);
    tick(1);
    chk("start_dout", dout, 4'b0101);
    chk("start_pulses", {rp, fp, lp}, 12'h000);

    // Ch0 release, then bounce and steady press.
    din[0] = 1'b0;
    tick(6);
    chk("ch0_fall_early", {dout[0], fp[0]}, 2'b10);
    tick(1);
    chk("ch0_fall", {dout[0], fp[0]}, 2'b01);
    tick(12);
    din[0] = 1'b1; tick(1);
    din[0] = 1'b0; tick(1);
    din[0] = 1'b1; tick(1);
    din[0] = 1'b0; tick(1);
    snap = rise_cnt[0];
    din[0] = 1'b1;
    tick(6);
    chk("ch0_bounce_norise", rise_cnt[0], snap);
    chk("ch0_low_still", dout[0], 1'b0);
    tick(1);
    chk("ch0_rise", {dout[0], rp}, 5'b1_0001);
    tick(1);
    chk("ch0_rise_1cyc", rp, 4'b0000);
    din[0] = 1'b0;
    tick(5);
    din[0] = 1'b1;
    snap = fall_cnt[0];
    tick(15);
    chk("ch0_lockout_nofall", fall_cnt[0], snap);
    chk("ch0_lockout_dout", dout[0], 1'b1);

    // Ch1 active-low, M = 3.
    rmin = 32'd3;
    din[1] = 1'b0;
    tick(4);
    chk("ch1_rise_early", dout[1], 1'b0);
    tick(1);
    chk("ch1_rise", {dout[1], rp}, 5'b1_0010);
    tick(15);
    din[1] = 1'b1;
    tick(6);
    chk("ch1_fall_early", fp[1], 1'b0);
    tick(1);
    chk("ch1_fall", {dout[1], fp}, 5'b0_0010);

    // Long press on ch2.
    din[0] = 1'b0;
    din[2] = 1'b0;
    tick(20);
    chk("lp_idle", dout, 4'b0000);
    lpc = 32'd100;
    din[2] = 1'b1;
    tick(4);
    chk("ch2_rise_early", rp[2], 1'b0);
    tick(1);
    chk("ch2_rise", rp, 4'b0100);
    snap = lp_cnt[2];
    tick(99);
    chk("lp_early", lp_cnt[2], snap);
    tick(1);
    chk("lp_fire", lp, 4'b0100);
    tick(195);
    chk("lp_once", lp_cnt[2], snap + 1);
    din[2] = 1'b0;
    tick(7);
    chk("ch2_fall", fp, 4'b0100);
    tick(20);
    lpc = 32'd0;
    din[2] = 1'b1;
    tick(5);
    chk("ch2_rise2", rp, 4'b0100);
    snap = lp_cnt[2];
    tick(200);
    chk("lp_disabled", lp_cnt[2], snap);
    din[2] = 1'b0;
    tick(20);

    // Threshold lowered mid-count on ch3; zero threshold acts as 1.
    rmin = 32'd1000;
    din[3] = 1'b1;
    tick(52);
    chk("ch3_midcount", dout[3], 1'b0);
    rmin = 32'd4;
    tick(1);
    chk("ch3_lowered_rise", {dout[3], rp}, 5'b1_1000);
    tick(12);
    fmin = 32'd0;
    din[3] = 1'b0;
    tick(2);
    chk("ch3_zero_early", dout[3], 1'b1);
    tick(1);
    chk("ch3_zero_fall", {dout[3], fp}, 5'b0_1000);
    fmin = 32'd5;
    rmin = 32'd5;
    tick(15);

    // Reset pulse while ch0 high and ch3 rising.
    din[0] = 1'b1;
    tick(20);
    chk("pre_rst_dout", dout, 4'b0001);
    din[3] = 1'b1;
    tick(3);
    snap = fall_cnt[0] + fall_cnt[3];
    reset = 1'b1;
    tick(1);
    chk("midrst_dout", dout, 4'b0000);
    chk("midrst_pulses", {rp, fp, lp}, 12'h000);
    reset = 1'b0;
    tick(3);
    chk("rerst_early", dout, 4'b0000);
    tick(1);
    chk("rerst_dout", dout, 4'b1001);
    chk("rerst_pulses", {rp, fp, lp}, 12'h000);
    chk("rerst_nofall", fall_cnt[0] + fall_cnt[3], snap);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
